// File: rtl/ddr_pkg.sv
// ddr_pkg -- shared types for the DDR4 controller command path.
//
// Contents:
//   req_cmd_e      : request codes handed to the ACT/CAS stage.
//   sched_fsm_type : read/write scheduler states.
//   sched_entry_t  : one queued host request {ap, addr} at the default
//                    controller address width.
//   req_code()     : maps direction + auto-precharge to a request code.
package ddr_pkg;

    typedef enum logic [2:0] {
        RD_R  = 3'd0,
        RDA_R = 3'd1,
        WR_R  = 3'd2,
        WRA_R = 3'd3
    } req_cmd_e;

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_RD   = 2'd1,
        SCH_WR   = 2'd2
    } sched_fsm_type;

    localparam int SCHED_ADDR_W = 32;

    typedef struct packed {
        logic                    ap;
        logic [SCHED_ADDR_W-1:0] addr;
    } sched_entry_t;

    // Codes are laid out so bit 1 is the direction and bit 0 the
    // auto-precharge flag.
    function automatic logic [2:0] req_code(input logic is_wr, input logic ap);
        return {1'b0, is_wr, ap};
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// sched_fifo -- request queue for the read/write scheduler.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (empties the queue)
//   push_i, data_i : write one entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry (valid while !empty_o)
//   count_o        : occupancy, 0..DEPTH
//   full_o/empty_o : derived from the registered count only
module sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];

    // A full queue never accepts, even if the head is popped this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_rw_sched.sv
// ctrl_rw_sched -- read/write request scheduler ahead of the ACT/CAS stage.
//
// Buffers host reads and writes in separate FIFOs and issues one request
// per cycle through a registered valid/ready output, batching up to
// MAX_BATCH same-direction requests before giving the other queue a turn.
//
// Ports:
//   CK_t, reset_n                       : clock, asynchronous active-low reset
//   rd_valid/rd_ready/rd_addr/rd_ap     : host read request channel
//   wr_valid/wr_ready/wr_addr/wr_ap     : host write request channel
//   req_valid/req_ready                 : handshake to the ACT stage
//   req_cmd/req_addr/req_turn           : offered request, turn = direction change
//   rd_count/wr_count                   : queue occupancies
//   wr_drain (SCHED_WR_DRAIN_EN only)   : forced write drain in progress
//
// Build option: define SCHED_WR_DRAIN_EN to enable the write-watermark drain.
module ctrl_rw_sched
    import ddr_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int Q_DEPTH   = 8,
    parameter int MAX_BATCH = 4,
    parameter int WR_HI_WM  = 6,
    parameter int WR_LO_WM  = 2
) (
    input  logic                       CK_t,
    input  logic                       reset_n,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_ap,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       wr_ap,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [2:0]                 req_cmd,
    output logic [ADDR_W-1:0]          req_addr,
    output logic                       req_turn,
    output logic [$clog2(Q_DEPTH):0]   rd_count,
    output logic [$clog2(Q_DEPTH):0]   wr_count
`ifdef SCHED_WR_DRAIN_EN
    ,
    output logic                       wr_drain
`endif
);
    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam int BW = $clog2(MAX_BATCH) + 1;
    localparam int EW = ADDR_W + 1;
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BATCH);

    if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ctrl_rw_sched: Q_DEPTH must be a power of two >= 2");
    end
    if (WR_LO_WM >= WR_HI_WM || WR_HI_WM > Q_DEPTH) begin : g_bad_wm
        $error("ctrl_rw_sched: need WR_LO_WM < WR_HI_WM <= Q_DEPTH");
    end

    // ---------------- queues ----------------
    logic [EW-1:0] rd_head, wr_head;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic          rd_full, rd_empty, wr_full, wr_empty;
    logic          rd_pop, wr_pop;

    sched_fifo #(.DEPTH(Q_DEPTH), .WIDTH(EW)) u_rd_q (
        .clk     (CK_t),
        .rst_n   (reset_n),
        .push_i  (rd_valid),
        .data_i  ({rd_ap, rd_addr}),
        .pop_i   (rd_pop),
        .head_o  (rd_head),
        .count_o (rd_cnt),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    sched_fifo #(.DEPTH(Q_DEPTH), .WIDTH(EW)) u_wr_q (
        .clk     (CK_t),
        .rst_n   (reset_n),
        .push_i  (wr_valid),
        .data_i  ({wr_ap, wr_addr}),
        .pop_i   (wr_pop),
        .head_o  (wr_head),
        .count_o (wr_cnt),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    assign rd_ready = !rd_full;
    assign wr_ready = !wr_full;
    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;

    // ---------------- scheduler state ----------------
    sched_fsm_type      state_q, state_d;
    logic [BW-1:0]      batch_q, batch_d;
    logic               last_vld_q, last_vld_d;   // a direction has been issued since reset
    logic               last_wr_q, last_wr_d;     // that direction was write
    logic               vld_q, vld_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               turn_q, turn_d;
`ifdef SCHED_WR_DRAIN_EN
    localparam logic [CW-1:0] HI_WM = CW'(WR_HI_WM);
    localparam logic [CW-1:0] LO_WM = CW'(WR_LO_WM);
    logic               drain_q, drain_d;
`endif

    logic               load;
    logic               go_rd, go_wr, sel_turn, wr_burst_ok;
    logic [BW-1:0]      sel_batch;

    assign req_valid = vld_q;
    assign req_cmd   = cmd_q;
    assign req_addr  = addr_q;
    assign req_turn  = turn_q;
`ifdef SCHED_WR_DRAIN_EN
    assign wr_drain  = drain_q;
`endif

    // The output register only takes a new request when it is empty or
    // its current request is being accepted on this edge.
    assign load = !vld_q || req_ready;

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCH_IDLE;
            batch_q    <= '0;
            last_vld_q <= 1'b0;
            last_wr_q  <= 1'b0;
            vld_q      <= 1'b0;
            cmd_q      <= RD_R;
            addr_q     <= '0;
            turn_q     <= 1'b0;
`ifdef SCHED_WR_DRAIN_EN
            drain_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            batch_q    <= batch_d;
            last_vld_q <= last_vld_d;
            last_wr_q  <= last_wr_d;
            vld_q      <= vld_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            turn_q     <= turn_d;
`ifdef SCHED_WR_DRAIN_EN
            drain_q    <= drain_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        last_vld_d = last_vld_q;
        last_wr_d  = last_wr_q;
        vld_d      = vld_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        turn_d     = turn_q;
        rd_pop     = 1'b0;
        wr_pop     = 1'b0;
        go_rd      = 1'b0;
        go_wr      = 1'b0;
        sel_turn   = 1'b0;
        sel_batch  = BW'(1);
        wr_burst_ok = (batch_q < MAX_B);
`ifdef SCHED_WR_DRAIN_EN
        drain_d    = drain_q;
        if (drain_q && wr_cnt <= LO_WM) begin
            drain_d = 1'b0;
        end
        // While draining, the write batch limit does not apply.
        wr_burst_ok = wr_burst_ok || drain_q;
`endif

        if (load) begin
            case (state_q)
                SCH_IDLE: begin
                    // Direction memory survives IDLE so a flip is still flagged.
                    if (!rd_empty) begin
                        go_rd    = 1'b1;
                        sel_turn = last_vld_q && last_wr_q;
                    end else if (!wr_empty) begin
                        go_wr    = 1'b1;
                        sel_turn = last_vld_q && !last_wr_q;
                    end
                end
                SCH_RD: begin
`ifdef SCHED_WR_DRAIN_EN
                    if (!wr_empty && wr_cnt >= HI_WM) begin
                        go_wr    = 1'b1;
                        sel_turn = 1'b1;
                        drain_d  = 1'b1;
                    end else
`endif
                    if (batch_q < MAX_B && !rd_empty) begin
                        go_rd     = 1'b1;
                        sel_batch = batch_q + BW'(1);
                    end else if (!wr_empty) begin
                        go_wr    = 1'b1;
                        sel_turn = 1'b1;
                    end else if (!rd_empty) begin
                        go_rd = 1'b1;
                    end
                end
                SCH_WR: begin
                    if (wr_burst_ok && !wr_empty) begin
                        go_wr     = 1'b1;
                        sel_batch = (batch_q >= MAX_B) ? MAX_B : batch_q + BW'(1);
                    end else if (!rd_empty) begin
                        go_rd    = 1'b1;
                        sel_turn = 1'b1;
                    end else if (!wr_empty) begin
                        go_wr = 1'b1;
                    end
                end
                default: ;
            endcase

            if (go_rd) begin
                state_d    = SCH_RD;
                batch_d    = sel_batch;
                vld_d      = 1'b1;
                cmd_d      = req_code(1'b0, rd_head[ADDR_W]);
                addr_d     = rd_head[ADDR_W-1:0];
                turn_d     = sel_turn;
                rd_pop     = 1'b1;
                last_vld_d = 1'b1;
                last_wr_d  = 1'b0;
            end else if (go_wr) begin
                state_d    = SCH_WR;
                batch_d    = sel_batch;
                vld_d      = 1'b1;
                cmd_d      = req_code(1'b1, wr_head[ADDR_W]);
                addr_d     = wr_head[ADDR_W-1:0];
                turn_d     = sel_turn;
                wr_pop     = 1'b1;
                last_vld_d = 1'b1;
                last_wr_d  = 1'b1;
            end else begin
                state_d = SCH_IDLE;
                batch_d = '0;
                vld_d   = 1'b0;
                turn_d  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_rw_sched.sv
module tb_ctrl_rw_sched;
    import ddr_pkg::*;

    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic              turn;
    } exp_t;

    logic              CK_t = 1'b0;
    logic              reset_n;
    logic              rd_valid, rd_ready, rd_ap;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid, wr_ready, wr_ap;
    logic [ADDR_W-1:0] wr_addr;
    logic              req_valid, req_ready, req_turn;
    logic [2:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        rd_count, wr_count;
`ifdef SCHED_WR_DRAIN_EN
    logic              wr_drain;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 CK_t = ~CK_t;

    ctrl_rw_sched #(
        .ADDR_W(ADDR_W), .Q_DEPTH(8), .MAX_BATCH(4), .WR_HI_WM(6), .WR_LO_WM(2)
    ) dut (
        .CK_t      (CK_t),
        .reset_n   (reset_n),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_ap     (rd_ap),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_ap     (wr_ap),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_turn  (req_turn),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`ifdef SCHED_WR_DRAIN_EN
        ,
        .wr_drain  (wr_drain)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every accepted request is checked against the scoreboard head.
    always @(negedge CK_t) begin
        if (reset_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_req: got cmd=%0d addr=%h turn=%0b expected none",
                         req_cmd, req_addr, req_turn);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (req_cmd !== e.cmd || req_addr !== e.addr || req_turn !== e.turn) begin
                    fails++;
                    $display("FAIL req_order: got cmd=%0d addr=%h turn=%0b expected cmd=%0d addr=%h turn=%0b",
                             req_cmd, req_addr, req_turn, e.cmd, e.addr, e.turn);
                end else begin
                    $display("[TB] req cmd=%0d addr=%h turn=%0b", req_cmd, req_addr, req_turn);
                end
            end
        end
    end

    task automatic expect_req(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr, input logic turn);
        exp_t e;
        e.cmd = cmd; e.addr = addr; e.turn = turn;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge CK_t);
            n++;
        end
        @(posedge CK_t); #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        chk({tag, "_req_cmd"},   64'(req_cmd),   64'(RD_R));
        chk({tag, "_req_addr"},  64'(req_addr),  64'd0);
        chk({tag, "_req_turn"},  64'(req_turn),  64'd0);
        chk({tag, "_rd_count"},  64'(rd_count),  64'd0);
        chk({tag, "_wr_count"},  64'(wr_count),  64'd0);
        chk({tag, "_rd_ready"},  64'(rd_ready),  64'd1);
        chk({tag, "_wr_ready"},  64'(wr_ready),  64'd1);
    endtask

    initial begin
        reset_n = 1'b0; req_ready = 1'b0;
        rd_valid = 1'b0; rd_addr = '0; rd_ap = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_ap = 1'b0;
        repeat (3) @(posedge CK_t);
        @(negedge CK_t);
        chk_reset_outputs("reset");
        @(posedge CK_t); #1;
        reset_n = 1'b1;

        // ---- single read: latency and fields ----
        req_ready = 1'b1;
        @(posedge CK_t); #1;
        rd_valid = 1'b1; rd_addr = 32'h40; rd_ap = 1'b0;
        expect_req(RD_R, 32'h40, 1'b0);
        @(posedge CK_t); #1;                 // push edge t
        rd_valid = 1'b0;
        chk("lat_t_valid", 64'(req_valid), 64'd0);
        chk("lat_t_rdcnt", 64'(rd_count), 64'd1);
        @(posedge CK_t); #1;                 // edge t+1
        chk("lat_t1_valid", 64'(req_valid), 64'd1);
        @(posedge CK_t); #1;                 // accepting edge
        chk("single_rdcnt", 64'(rd_count), 64'd0);
        chk("single_idle", 64'(req_valid), 64'd0);
        wait_drain("single_drain", 10);

        // ---- 6 reads + 2 writes, batching and stall stability ----
        req_ready = 1'b0;
        expect_req(RD_R,  32'h100, 1'b0);
        expect_req(RDA_R, 32'h104, 1'b0);
        expect_req(RD_R,  32'h108, 1'b0);
        expect_req(RD_R,  32'h10C, 1'b0);
        expect_req(WRA_R, 32'h200, 1'b1);
        expect_req(WR_R,  32'h204, 1'b0);
        expect_req(RD_R,  32'h110, 1'b1);
        expect_req(RD_R,  32'h114, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge CK_t); #1;
            rd_valid = 1'b1; rd_addr = 32'h100 + 32'(4 * i); rd_ap = (i == 1);
            wr_valid = (i < 2); wr_addr = 32'h200 + 32'(4 * i); wr_ap = (i == 0);
        end
        @(posedge CK_t); #1;
        rd_valid = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK_t);
            chk("stall_valid", 64'(req_valid), 64'd1);
            chk("stall_cmd",   64'(req_cmd),   64'(RD_R));
            chk("stall_addr",  64'(req_addr),  64'h100);
            chk("stall_turn",  64'(req_turn),  64'd0);
        end
        chk("mix_rdcnt", 64'(rd_count), 64'd5);
        chk("mix_wrcnt", 64'(wr_count), 64'd2);
        @(posedge CK_t); #1;
        req_ready = 1'b1;
        wait_drain("mix_drain", 40);

        // ---- write queue full ----
        req_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge CK_t); #1;
            chk("wrfill_ready", 64'(wr_ready), 64'd1);
            wr_valid = 1'b1; wr_addr = 32'h300 + 32'(4 * i); wr_ap = 1'b0;
            expect_req(WR_R, 32'h300 + 32'(4 * i), (i == 0));
        end
        @(posedge CK_t); #1;                 // 9th push accepted here
        wr_addr = 32'h3FC;                   // 10th must be refused
        chk("full_wrcnt", 64'(wr_count), 64'd8);
        chk("full_ready", 64'(wr_ready), 64'd0);
        @(posedge CK_t); #1;
        chk("full_hold_cnt", 64'(wr_count), 64'd8);
        wr_valid = 1'b0;
        req_ready = 1'b1;
        @(posedge CK_t); #1;                 // one accept
        req_ready = 1'b0;
        chk("after_acc_ready", 64'(wr_ready), 64'd1);
        chk("after_acc_cnt", 64'(wr_count), 64'd7);
        req_ready = 1'b1;
        wait_drain("full_drain", 40);

        // ---- reset mid-batch ----
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CK_t); #1;
            rd_valid = 1'b1; rd_addr = 32'h400 + 32'(4 * i); rd_ap = 1'b0;
        end
        @(posedge CK_t); #1;
        rd_valid = 1'b0;
        chk("prerst_rdcnt", 64'(rd_count), 64'd3);
        chk("prerst_valid", 64'(req_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge CK_t); #1;
        reset_n = 1'b1;
        req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK_t);
            chk("no_stale", 64'(req_valid), 64'd0);
        end
        @(posedge CK_t); #1;
        wr_valid = 1'b1; wr_addr = 32'h500; wr_ap = 1'b0;
        expect_req(WR_R, 32'h500, 1'b0);
        @(posedge CK_t); #1;
        wr_valid = 1'b0;
        wait_drain("post_rst_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
